// File: rtl/uart_cmd_responder_if.sv
// Byte-level link between the UART rx/tx paths, the ROM port and the command responder.
// master: the responder side; slave: the UART/ROM environment side.
interface uart_cmd_responder_if;
    // rx_ready and tx_ready are single-cycle pulses. The responder raises tx_req and holds
    // tx_data stable until it sees the tx_ready pulse. No backpressure is applied on rx.
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic [15:0] rom_addr;
    logic [7:0]  rom_wdata;
    logic        rom_we;
    logic        rom_rd;
    logic [7:0]  rom_rdata;

    modport master (
        input  rx_ready, rx_data, tx_ready, rom_rdata,
        output tx_req, tx_data, rom_addr, rom_wdata, rom_we, rom_rd
    );

    modport slave (
        output rx_ready, rx_data, tx_ready, rom_rdata,
        input  tx_req, tx_data, rom_addr, rom_wdata, rom_we, rom_rd
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Serial command responder: decodes W/R/I host commands into ROM strobes and sends one reply byte.
// Optional trailing XOR checksum byte on every known command when CHECKSUM_EN is defined.
module uart_cmd_responder #(
    parameter logic [7:0]  DEV_ID   = 8'hA5,
    parameter int unsigned READ_LAT = 2,
    parameter logic [23:0] TIMEOUT  = 24'd5_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_cmd_responder_if.master        bus,
    output logic                        busy,
    output logic                        overrun,
    output logic [3:0]                  state_dbg
);
    localparam logic [7:0] OP_W  = 8'h57;
    localparam logic [7:0] OP_R  = 8'h52;
    localparam logic [7:0] OP_I  = 8'h49;
    localparam logic [7:0] RPL_K = 8'h4B;
    localparam logic [7:0] RPL_Q = 8'h3F;
`ifdef CHECKSUM_EN
    localparam logic [7:0] RPL_E = 8'h45;
`endif
    localparam logic [3:0] LAT   = 4'(READ_LAT);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR_HI  = 4'd1,
        ADDR_LO  = 4'd2,
        DATA     = 4'd3,
        MEM_WR   = 4'd4,
        MEM_RD   = 4'd5,
        TX_START = 4'd6,
        TX_WAIT  = 4'd7
`ifdef CHECKSUM_EN
        ,
        CHECK    = 4'd8
`endif
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  opcode, opcode_nx;
    logic [15:0] addr_q, addr_nx;
    logic [7:0]  wdata_q, wdata_nx;
    logic [7:0]  tx_data_q, tx_data_nx;
    logic        tx_req_q, tx_req_nx;
    logic [23:0] tmo_cnt, tmo_cnt_nx;
    logic [3:0]  lat_cnt, lat_cnt_nx;
    logic        pend_valid, pend_valid_nx;
    logic [7:0]  pend_data, pend_data_nx;
    logic        overrun_q, overrun_nx;
    logic        rom_we_c, rom_rd_c;
`ifdef CHECKSUM_EN
    logic [7:0]  ck_acc, ck_acc_nx;
    logic        ck_done, ck_done_nx;
    logic        ck_ok, ck_ok_nx;
`endif

    logic        waiting;
    logic        busy_drop;
    logic        timed_out;
    logic        accept;
    logic        first_valid;
    logic [7:0]  first_data;

    // A byte that collided with a timeout is replayed from pend_* as the next opcode.
    assign first_valid = pend_valid | bus.rx_ready;
    assign first_data  = pend_valid ? pend_data : bus.rx_data;

    always_comb begin
        waiting   = 1'b0;
        busy_drop = 1'b0;
        case (state)
            ADDR_HI, ADDR_LO, DATA:            waiting   = 1'b1;
            MEM_WR, MEM_RD, TX_START, TX_WAIT: busy_drop = 1'b1;
`ifdef CHECKSUM_EN
            CHECK: begin
                waiting   = !ck_done;
                busy_drop = ck_done;
            end
`endif
            default: begin
                waiting   = 1'b0;
                busy_drop = 1'b0;
            end
        endcase
    end

    assign timed_out  = waiting && (tmo_cnt == TIMEOUT);
    assign accept     = waiting && bus.rx_ready && !timed_out;
    assign tmo_cnt_nx = (waiting && !accept && !timed_out) ? tmo_cnt + 24'd1 : 24'd0;
    assign overrun_nx = bus.rx_ready && (busy_drop || (state == IDLE && pend_valid));

    always_comb begin
        state_nx      = state;
        opcode_nx     = opcode;
        addr_nx       = addr_q;
        wdata_nx      = wdata_q;
        tx_data_nx    = tx_data_q;
        tx_req_nx     = tx_req_q;
        lat_cnt_nx    = 4'd0;
        pend_valid_nx = 1'b0;
        pend_data_nx  = pend_data;
        rom_we_c      = 1'b0;
        rom_rd_c      = 1'b0;
`ifdef CHECKSUM_EN
        ck_acc_nx     = ck_acc;
        ck_done_nx    = ck_done;
        ck_ok_nx      = ck_ok;
`endif
        if (timed_out) begin
            state_nx      = IDLE;
            pend_valid_nx = bus.rx_ready;
            pend_data_nx  = bus.rx_data;
        end else begin
            case (state)
                IDLE: begin
                    if (first_valid) begin
                        opcode_nx = first_data;
`ifdef CHECKSUM_EN
                        ck_acc_nx  = first_data;
                        ck_done_nx = 1'b0;
                        ck_ok_nx   = 1'b0;
`endif
                        case (first_data)
                            OP_W, OP_R: state_nx = ADDR_HI;
                            OP_I: begin
`ifdef CHECKSUM_EN
                                state_nx = CHECK;
`else
                                tx_data_nx = DEV_ID;
                                state_nx   = TX_START;
`endif
                            end
                            default: begin
                                tx_data_nx = RPL_Q;
                                state_nx   = TX_START;
                            end
                        endcase
                    end
                end
                ADDR_HI: begin
                    if (accept) begin
                        addr_nx  = {bus.rx_data, addr_q[7:0]};
                        state_nx = ADDR_LO;
`ifdef CHECKSUM_EN
                        ck_acc_nx = ck_acc ^ bus.rx_data;
`endif
                    end
                end
                ADDR_LO: begin
                    if (accept) begin
                        addr_nx = {addr_q[15:8], bus.rx_data};
`ifdef CHECKSUM_EN
                        ck_acc_nx = ck_acc ^ bus.rx_data;
                        state_nx  = (opcode == OP_W) ? DATA : CHECK;
`else
                        state_nx  = (opcode == OP_W) ? DATA : MEM_RD;
`endif
                    end
                end
                DATA: begin
                    if (accept) begin
                        wdata_nx = bus.rx_data;
`ifdef CHECKSUM_EN
                        ck_acc_nx = ck_acc ^ bus.rx_data;
                        state_nx  = CHECK;
`else
                        state_nx  = MEM_WR;
`endif
                    end
                end
`ifdef CHECKSUM_EN
                // Compare on the cycle after CK arrives, then dispatch.
                CHECK: begin
                    if (ck_done) begin
                        ck_done_nx = 1'b0;
                        if (!ck_ok) begin
                            tx_data_nx = RPL_E;
                            state_nx   = TX_START;
                        end else if (opcode == OP_W) begin
                            state_nx = MEM_WR;
                        end else if (opcode == OP_R) begin
                            state_nx = MEM_RD;
                        end else begin
                            tx_data_nx = DEV_ID;
                            state_nx   = TX_START;
                        end
                    end else if (accept) begin
                        ck_ok_nx   = (bus.rx_data == ck_acc);
                        ck_done_nx = 1'b1;
                    end
                end
`endif
                MEM_WR: begin
                    rom_we_c   = 1'b1;
                    tx_data_nx = RPL_K;
                    state_nx   = TX_START;
                end
                MEM_RD: begin
                    rom_rd_c = (lat_cnt == 4'd0);
                    if (lat_cnt == LAT) begin
                        tx_data_nx = bus.rom_rdata;
                        state_nx   = TX_START;
                    end else begin
                        lat_cnt_nx = lat_cnt + 4'd1;
                    end
                end
                TX_START: begin
                    tx_req_nx = 1'b1;
                    state_nx  = TX_WAIT;
                end
                TX_WAIT: begin
                    if (bus.tx_ready) begin
                        tx_req_nx = 1'b0;
                        state_nx  = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            opcode     <= 8'd0;
            addr_q     <= 16'd0;
            wdata_q    <= 8'd0;
            tx_data_q  <= 8'd0;
            tx_req_q   <= 1'b0;
            tmo_cnt    <= 24'd0;
            lat_cnt    <= 4'd0;
            pend_valid <= 1'b0;
            pend_data  <= 8'd0;
            overrun_q  <= 1'b0;
`ifdef CHECKSUM_EN
            ck_acc     <= 8'd0;
            ck_done    <= 1'b0;
            ck_ok      <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            opcode     <= opcode_nx;
            addr_q     <= addr_nx;
            wdata_q    <= wdata_nx;
            tx_data_q  <= tx_data_nx;
            tx_req_q   <= tx_req_nx;
            tmo_cnt    <= tmo_cnt_nx;
            lat_cnt    <= lat_cnt_nx;
            pend_valid <= pend_valid_nx;
            pend_data  <= pend_data_nx;
            overrun_q  <= overrun_nx;
`ifdef CHECKSUM_EN
            ck_acc     <= ck_acc_nx;
            ck_done    <= ck_done_nx;
            ck_ok      <= ck_ok_nx;
`endif
        end
    end

    assign bus.tx_req    = tx_req_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.rom_addr  = addr_q;
    assign bus.rom_wdata = wdata_q;
    assign bus.rom_we    = rom_we_c;
    assign bus.rom_rd    = rom_rd_c;
    assign busy          = (state != IDLE);
    assign overrun       = overrun_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: write, read, id/unknown, timeout, overrun, reset.
module tb_uart_cmd_responder;
  localparam logic [23:0] T_OUT = 24'd20;
  localparam int LAT = 2;
`ifdef CHECKSUM_EN
  localparam int CKX = 1;
`else
  localparam int CKX = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, overrun;
  logic [3:0] state_dbg;

  uart_cmd_responder_if bus();

  uart_cmd_responder #(.DEV_ID(8'hA5), .READ_LAT(LAT), .TIMEOUT(T_OUT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .overrun(overrun), .state_dbg(state_dbg)
  );

  // clock/reset
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: data valid exactly LAT cycles after the read strobe
  logic [7:0] rom_val = 8'h00;
  logic [LAT-1:0] rd_pipe;
  always @(posedge clk or negedge reset)
    if (!reset) rd_pipe <= '0;
    else rd_pipe <= {rd_pipe[LAT-2:0], bus.rom_rd};
  assign bus.rom_rdata = rd_pipe[LAT-1] ? rom_val : 8'h00;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int reply_cnt = 0, reply_cyc = 0, last_rx_cyc = 0;
  int we_cnt = 0, rd_cnt = 0, ovr_cnt = 0;
  logic [15:0] we_addr = 16'h0, rd_addr = 16'h0;
  logic [7:0] we_data = 8'h0;
  logic prev_req = 1'b0;

  // scoreboard / monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      if (bus.rom_we) begin we_cnt++; we_addr = bus.rom_addr; we_data = bus.rom_wdata; end
      if (bus.rom_rd) begin rd_cnt++; rd_addr = bus.rom_addr; end
      if (overrun) ovr_cnt++;
      if (bus.tx_req && !prev_req) begin
        reply_cnt++;
        reply_cyc = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL reply_unexpected got=%h required=none", bus.tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.tx_data !== e) begin
            n_err++;
            $display("FAIL reply_value got=%h required=%h", bus.tx_data, e);
          end
        end
      end
      prev_req = bus.tx_req;
    end else begin
      prev_req = 1'b0;
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_ready = 1'b1;
    bus.rx_data = b;
    last_rx_cyc = cyc;
    step();
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_reply(input int prev);
    for (int i = 0; i < 200; i++) begin
      if (reply_cnt > prev) break;
      step();
    end
  endtask

  task automatic tx_ack();
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.rx_ready = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
    reset = 1'b0;
    repeat (3) step();
    n_cmp++; if (bus.tx_req !== 1'b0) begin n_err++; $display("FAIL rst_tx_req got=%b required=0", bus.tx_req); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data got=%h required=00", bus.tx_data); end
    n_cmp++; if (bus.rom_addr !== 16'h0000) begin n_err++; $display("FAIL rst_rom_addr got=%h required=0000", bus.rom_addr); end
    n_cmp++; if (bus.rom_wdata !== 8'h00) begin n_err++; $display("FAIL rst_rom_wdata got=%h required=00", bus.rom_wdata); end
    n_cmp++; if ({bus.rom_we, bus.rom_rd} !== 2'b00) begin n_err++; $display("FAIL rst_strobes got=%b required=00", {bus.rom_we, bus.rom_rd}); end
    n_cmp++; if ({busy, overrun} !== 2'b00) begin n_err++; $display("FAIL rst_busy_ovr got=%b required=00", {busy, overrun}); end
    n_cmp++; if (state_dbg !== 4'd0) begin n_err++; $display("FAIL rst_state got=%0d required=0", state_dbg); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_write();
    int r0 = reply_cnt;
    int w0 = we_cnt;
    int d0 = rd_cnt;
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA7);
`ifdef CHECKSUM_EN
    send_byte(8'hD6);
`endif
    wait_reply(r0);
    n_cmp++; if (reply_cnt != r0 + 1) begin n_err++; $display("FAIL wr_reply_count got=%0d required=%0d", reply_cnt - r0, 1); end
    n_cmp++; if (reply_cyc - last_rx_cyc != 3 + CKX) begin n_err++; $display("FAIL wr_latency got=%0d required=%0d", reply_cyc - last_rx_cyc, 3 + CKX); end
    n_cmp++; if (we_cnt != w0 + 1) begin n_err++; $display("FAIL wr_we_pulses got=%0d required=1", we_cnt - w0); end
    n_cmp++; if (we_addr !== 16'h1234) begin n_err++; $display("FAIL wr_addr got=%h required=1234", we_addr); end
    n_cmp++; if (we_data !== 8'hA7) begin n_err++; $display("FAIL wr_data got=%h required=a7", we_data); end
    n_cmp++; if (rd_cnt != d0) begin n_err++; $display("FAIL wr_no_rd got=%0d required=0", rd_cnt - d0); end
    step();
    n_cmp++; if ({bus.tx_req, busy} !== 2'b11) begin n_err++; $display("FAIL wr_hold got=%b required=11", {bus.tx_req, busy}); end
    tx_ack();
    n_cmp++; if ({bus.tx_req, busy} !== 2'b00) begin n_err++; $display("FAIL wr_done got=%b required=00", {bus.tx_req, busy}); end
    n_cmp++; if ({bus.rom_addr, bus.rom_wdata} !== 24'h1234A7) begin n_err++; $display("FAIL wr_retain got=%h required=1234a7", {bus.rom_addr, bus.rom_wdata}); end
  endtask

  task automatic test_read();
    int r0 = reply_cnt;
    int d0 = rd_cnt;
    int w0 = we_cnt;
    rom_val = 8'h5C;
    exp_q.push_back(8'h5C);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
`ifdef CHECKSUM_EN
    send_byte(8'h42);
`endif
    wait_reply(r0);
    n_cmp++; if (reply_cnt != r0 + 1) begin n_err++; $display("FAIL rd_reply_count got=%0d required=1", reply_cnt - r0); end
    n_cmp++; if (reply_cyc - last_rx_cyc != LAT + 3 + CKX) begin n_err++; $display("FAIL rd_latency got=%0d required=%0d", reply_cyc - last_rx_cyc, LAT + 3 + CKX); end
    n_cmp++; if (rd_cnt != d0 + 1) begin n_err++; $display("FAIL rd_pulses got=%0d required=1", rd_cnt - d0); end
    n_cmp++; if (rd_addr !== 16'h0010) begin n_err++; $display("FAIL rd_addr got=%h required=0010", rd_addr); end
    n_cmp++; if (we_cnt != w0) begin n_err++; $display("FAIL rd_no_we got=%0d required=0", we_cnt - w0); end
    n_cmp++; if (bus.tx_data !== 8'h5C) begin n_err++; $display("FAIL rd_tx_data got=%h required=5c", bus.tx_data); end
    tx_ack();
  endtask

  task automatic test_id_unknown();
    int r0 = reply_cnt;
    int s0 = we_cnt + rd_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'h49);
`ifdef CHECKSUM_EN
    send_byte(8'h49);
`endif
    wait_reply(r0);
    n_cmp++; if (reply_cyc - last_rx_cyc != 2 + CKX) begin n_err++; $display("FAIL id_latency got=%0d required=%0d", reply_cyc - last_rx_cyc, 2 + CKX); end
    n_cmp++; if (bus.tx_data !== 8'hA5) begin n_err++; $display("FAIL id_tx_data got=%h required=a5", bus.tx_data); end
    tx_ack();
    exp_q.push_back(8'h3F);
    send_byte(8'h00);
    wait_reply(r0 + 1);
    n_cmp++; if (reply_cnt != r0 + 2) begin n_err++; $display("FAIL unk_reply_count got=%0d required=2", reply_cnt - r0); end
    n_cmp++; if (reply_cyc - last_rx_cyc != 2) begin n_err++; $display("FAIL unk_latency got=%0d required=2", reply_cyc - last_rx_cyc); end
    n_cmp++; if (we_cnt + rd_cnt != s0) begin n_err++; $display("FAIL idunk_no_strobe got=%0d required=0", we_cnt + rd_cnt - s0); end
    tx_ack();
  endtask

  task automatic test_timeout();
    int r0 = reply_cnt;
    int w0 = we_cnt;
    int o0 = ovr_cnt;
    send_byte(8'h57); send_byte(8'h12);
    repeat (int'(T_OUT) + 1) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_idle got=%b required=0", busy); end
    n_cmp++; if (reply_cnt != r0) begin n_err++; $display("FAIL tmo_no_reply got=%0d required=0", reply_cnt - r0); end
    exp_q.push_back(8'hA5);
    send_byte(8'h49);
`ifdef CHECKSUM_EN
    send_byte(8'h49);
`endif
    wait_reply(r0);
    n_cmp++; if (reply_cnt != r0 + 1) begin n_err++; $display("FAIL tmo_single_reply got=%0d required=1", reply_cnt - r0); end
    tx_ack();
    // a byte landing on the timeout cycle becomes the next opcode
    send_byte(8'h57); send_byte(8'h12);
    repeat (int'(T_OUT)) step();
    exp_q.push_back(8'hA5);
    send_byte(8'h49);
`ifdef CHECKSUM_EN
    step();
    send_byte(8'h49);
`endif
    wait_reply(r0 + 1);
    n_cmp++; if (reply_cnt != r0 + 2) begin n_err++; $display("FAIL tmo_edge_reply got=%0d required=1", reply_cnt - r0 - 1); end
    n_cmp++; if (ovr_cnt != o0) begin n_err++; $display("FAIL tmo_edge_no_drop got=%0d required=0", ovr_cnt - o0); end
    n_cmp++; if (we_cnt != w0) begin n_err++; $display("FAIL tmo_no_we got=%0d required=0", we_cnt - w0); end
    tx_ack();
  endtask

  task automatic test_overrun();
    int r0 = reply_cnt;
    int o0 = ovr_cnt;
    int d0 = rd_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'h49);
`ifdef CHECKSUM_EN
    send_byte(8'h49);
`endif
    wait_reply(r0);
    step();
    send_byte(8'h52);
    step();
    n_cmp++; if (ovr_cnt != o0 + 1) begin n_err++; $display("FAIL ovr_pulses got=%0d required=1", ovr_cnt - o0); end
    n_cmp++; if ({bus.tx_req, bus.tx_data} !== 9'h1A5) begin n_err++; $display("FAIL ovr_inflight got=%h required=1a5", {bus.tx_req, bus.tx_data}); end
    tx_ack();
    rom_val = 8'h3C;
    exp_q.push_back(8'h3C);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
`ifdef CHECKSUM_EN
    send_byte(8'h72);
`endif
    wait_reply(r0 + 1);
    n_cmp++; if (reply_cnt != r0 + 2) begin n_err++; $display("FAIL ovr_next_reply got=%0d required=2", reply_cnt - r0); end
    n_cmp++; if ({rd_cnt - d0, rd_addr} !== {32'd1, 16'h0020}) begin n_err++; $display("FAIL ovr_next_read got=%0d/%h required=1/0020", rd_cnt - d0, rd_addr); end
    tx_ack();
  endtask

  task automatic test_reset_mid();
    int r0 = reply_cnt;
    int w0 = we_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'h49);
`ifdef CHECKSUM_EN
    send_byte(8'h49);
`endif
    wait_reply(r0);
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if ({bus.tx_req, busy} !== 2'b00) begin n_err++; $display("FAIL rstmid_tx got=%b required=00", {bus.tx_req, busy}); end
    step(); reset = 1'b1; step();
    send_byte(8'h57); send_byte(8'h12);
    reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_cmd got=%b required=0", busy); end
    step(); reset = 1'b1; step();
    exp_q.push_back(8'hA5);
    send_byte(8'h49);
`ifdef CHECKSUM_EN
    send_byte(8'h49);
`endif
    wait_reply(r0 + 1);
    n_cmp++; if (reply_cnt != r0 + 2) begin n_err++; $display("FAIL rstmid_after got=%0d required=2", reply_cnt - r0); end
    n_cmp++; if (we_cnt != w0) begin n_err++; $display("FAIL rstmid_no_we got=%0d required=0", we_cnt - w0); end
    tx_ack();
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    int r0 = reply_cnt;
    int s0 = we_cnt + rd_cnt;
    exp_q.push_back(8'h45);
    send_byte(8'h49); send_byte(8'h48);
    wait_reply(r0);
    n_cmp++; if (bus.tx_data !== 8'h45) begin n_err++; $display("FAIL ck_bad_id got=%h required=45", bus.tx_data); end
    n_cmp++; if (reply_cyc - last_rx_cyc != 3) begin n_err++; $display("FAIL ck_bad_latency got=%0d required=3", reply_cyc - last_rx_cyc); end
    tx_ack();
    exp_q.push_back(8'h45);
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA7); send_byte(8'h00);
    wait_reply(r0 + 1);
    n_cmp++; if (bus.tx_data !== 8'h45) begin n_err++; $display("FAIL ck_bad_wr got=%h required=45", bus.tx_data); end
    n_cmp++; if (we_cnt + rd_cnt != s0) begin n_err++; $display("FAIL ck_bad_no_strobe got=%0d required=0", we_cnt + rd_cnt - s0); end
    tx_ack();
    exp_q.push_back(8'hA5);
    send_byte(8'h49); send_byte(8'h49);
    wait_reply(r0 + 2);
    n_cmp++; if (reply_cnt != r0 + 3) begin n_err++; $display("FAIL ck_good_id got=%0d required=3", reply_cnt - r0); end
    tx_ack();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_id_unknown();
    test_timeout();
    test_overrun();
    test_reset_mid();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    repeat (5) step();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL missing_replies got=%0d required=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
